// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and its receive-side counterpart.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte push handshake between the MCU core and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous circular byte FIFO; full/empty derived from the occupancy count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic [FIFO_DEPTH_LOG2:0]  count,
  output logic                      full,
  output logic                      empty
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [UART_DATA_BITS-1:0]  mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic                       do_push;
  logic                       do_pop;

  assign full    = (count == DEPTH[FIFO_DEPTH_LOG2:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(depth) wide, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8 data bits, no parity, 1 or 2 stop bits) fed from a byte FIFO.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit(s), high; chains straight into START if more bytes wait
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int STOP_BITS       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_if.slave                 bus,
  output logic                     TXD,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_n;
  logic [CNT_W-1:0]          baud_cnt, baud_n;
  logic [2:0]                bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
  logic                      txd_n;
  logic                      pop;
  logic                      baud_done;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  uart_tx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.tx_valid),
    .pop   (pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.tx_ready = !fifo_full;
  assign busy         = (state != IDLE) || !fifo_empty;
  assign baud_done    = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      TXD       <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      TXD       <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    txd_n   = TXD;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          txd_n   = 1'b0;
          baud_n  = BIT_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          txd_n   = shift_reg[0];
          bit_n   = '0;
          baud_n  = BIT_LOAD;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == LAST_BIT) begin
            txd_n   = 1'b1;
            baud_n  = STOP_LOAD;
            state_n = STOP;
          end else begin
            shift_n = shift_reg >> 1;
            txd_n   = shift_reg[1];
            bit_n   = bit_idx + 1'b1;
            baud_n  = BIT_LOAD;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (baud_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            txd_n   = 1'b0;
            baud_n  = BIT_LOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A push against a full FIFO wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                             overflow <= 1'b0;
    else if (bus.tx_valid && fifo_full)    overflow <= 1'b1;
    else if (overflow_clr)                 overflow <= 1'b0;
  end

endmodule
